// File: rtl/matrix_stream_pkg.sv
// Shared constants and FSM encoding for the matrix-multiplier stream stimulus.
package matrix_stream_pkg;

  localparam int unsigned AxisDataWidth = 32;

  typedef enum logic [2:0] {
    StWait,
    StSendA,
    StSendB,
    StGap,
    StDone
  } stream_state_e;

  // Index width for a frame of 2*dim*dim words (never narrower than one bit).
  function automatic int unsigned word_idx_width(input int unsigned dim);
    int unsigned w;
    w = $clog2(2 * dim * dim);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counting cycle timer: restarts at zero on load, flags the final cycle of a
// limit-cycle interval while enabled.
module cycle_timer #(
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;
  logic [Width:0]   count_inc;

  assign count_inc = {1'b0, count_q} + 1'b1;
  // A limit of zero behaves like one so the timer can never stall.
  assign tc_o      = count_inc >= {1'b0, limit_i};

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_inc[Width-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matrix_stimulus_rt.sv
// Self-timed AXI-Stream source: after a start delay, sends constant-filled A then B
// matrices per frame, with optional gap, frame limit and word-0 error injection.
module matrix_stimulus_rt
  import matrix_stream_pkg::*;
#(
  parameter int unsigned              Start_Delay = 20000,
  parameter int unsigned              Gap_Cycles  = 16,
  parameter int unsigned              Num_Frames  = 1,
  parameter int unsigned              DIM         = 3,
  parameter logic [AxisDataWidth-1:0] Val_A       = 32'd2,
  parameter logic [AxisDataWidth-1:0] Val_B       = 32'd7
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [AxisDataWidth-1:0] input_r_TDATA_0,
  output logic                     input_r_TVALID_0,
  input  logic                     input_r_TREADY_0,
  output logic                     input_r_TLAST_0,
  input  logic                     inject_error,
  output logic [7:0]               Frames_Sent,
  output logic                     done
);

  localparam int unsigned           TimerWidth = 20;
  localparam int unsigned           IdxWidth   = word_idx_width(DIM);
  localparam logic [IdxWidth-1:0]   LastWordA  = IdxWidth'(DIM * DIM - 1);
  localparam logic [IdxWidth-1:0]   LastWord   = IdxWidth'(2 * DIM * DIM - 1);
  localparam logic [TimerWidth-1:0] StartLimit = TimerWidth'(Start_Delay);
  localparam logic [TimerWidth-1:0] GapLimit   = TimerWidth'(Gap_Cycles);
  localparam logic [7:0]            FrameLimit = 8'(Num_Frames);

  stream_state_e              state_q, state_d;
  logic [IdxWidth-1:0]        idx_q, idx_d;
  logic                       err_q, err_d;
  logic [7:0]                 frames_q, frames_d, frames_inc;
  logic                       done_q, done_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic [AxisDataWidth-1:0]   tdata_q, tdata_d;
  logic                       fire;
  logic                       timer_load, timer_en, timer_tc;
  logic [TimerWidth-1:0]      timer_limit;

  assign fire        = tvalid_q & input_r_TREADY_0;
  assign frames_inc  = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;
  assign timer_limit = (state_q == StGap) ? GapLimit : StartLimit;

  cycle_timer #(
    .Width (TimerWidth)
  ) u_cycle_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .limit_i (timer_limit),
    .tc_o    (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    frames_d   = frames_q;
    done_d     = done_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      StWait: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          state_d = StSendA;
          idx_d   = '0;
          err_d   = inject_error;
        end
      end
      StSendA: begin
        if (fire) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LastWordA) begin
            state_d = StSendB;
          end
        end
      end
      StSendB: begin
        if (fire) begin
          if (idx_q == LastWord) begin
            frames_d = frames_inc;
            if (FrameLimit != 8'd0 && frames_inc == FrameLimit) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (Gap_Cycles == 0) begin
              state_d = StSendA;
              idx_d   = '0;
              err_d   = inject_error;
            end else begin
              state_d    = StGap;
              timer_load = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StGap: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          state_d = StSendA;
          idx_d   = '0;
          err_d   = inject_error;
        end
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = StWait;
      end
    endcase

    // Outputs are registered from next state, so a stalled word simply re-registers itself.
    tvalid_d = (state_d == StSendA) || (state_d == StSendB);
    tlast_d  = (state_d == StSendB) && (idx_d == LastWord);
    tdata_d  = '0;
    if (state_d == StSendA) begin
      tdata_d = (err_d && idx_d == '0) ? Val_A + 32'd1 : Val_A;
    end else if (state_d == StSendB) begin
      tdata_d = Val_B;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StWait;
      idx_q    <= '0;
      err_q    <= 1'b0;
      frames_q <= '0;
      done_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      frames_q <= frames_d;
      done_q   <= done_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign input_r_TDATA_0  = tdata_q;
  assign input_r_TVALID_0 = tvalid_q;
  assign input_r_TLAST_0  = tlast_q;
  assign Frames_Sent      = frames_q;
  assign done             = done_q;

endmodule
